// File: rtl/ajw_alu_pkg.sv
// Shared ALU package: datapath width, default lookahead group size and word type.
package ajw_alu_pkg;
  localparam int XLEN      = 32;
  localparam int CLA_GROUP = 4;

  typedef logic [XLEN-1:0] word_t;
endpackage

// File: rtl/ajw_cla_group.sv
// One carry-lookahead group: flattened in-group carries plus group generate/propagate.
import ajw_alu_pkg::*;

module ajw_cla_group #(
  parameter int GROUP = CLA_GROUP
) (
  input  logic [GROUP-1:0] op_x,
  input  logic [GROUP-1:0] op_y,
  input  logic             cin,
  output logic [GROUP-1:0] sum,
  output logic             gg,
  output logic             gp
);

  logic [GROUP-1:0] g;
  logic [GROUP-1:0] p;
  logic [GROUP-1:0] c;

  assign g = op_x & op_y;
  assign p = op_x ^ op_y;

  // GG/GP must not depend on cin so the group-level lookahead has no loop.
  always_comb begin
    logic term;
    gg   = 1'b0;
    term = 1'b0;
    for (int j = 0; j < GROUP; j++) begin
      term = g[j];
      for (int k = j + 1; k < GROUP; k++) term = term & p[k];
      gg = gg | term;
    end
    gp = &p;
  end

  // c[i] = g[i-1] | p[i-1]&g[i-2] | ... | p[i-1..0]&cin, as a sum of products
  always_comb begin
    logic acc;
    logic term;
    c    = '0;
    acc  = 1'b0;
    term = 1'b0;
    for (int i = 0; i < GROUP; i++) begin
      acc = cin;
      for (int j = 0; j < i; j++) acc = acc & p[j];
      for (int j = 0; j < i; j++) begin
        term = g[j];
        for (int k = j + 1; k < i; k++) term = term & p[k];
        acc = acc | term;
      end
      c[i] = acc;
    end
  end

  assign sum = p ^ c;

endmodule

// File: rtl/ajw_addsub_core.sv
// Registered two-level carry-lookahead adder; subtraction via inverted opY_i and cin_i=1.
// Define AJW_ADDSUB_FLAGS_EN to add the registered ovf_o and zero_o flags.
import ajw_alu_pkg::*;

module ajw_addsub_core #(
  parameter int WIDTH = XLEN,
  parameter int GROUP = CLA_GROUP
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] opX_i,
  input  logic [WIDTH-1:0] opY_i,
  input  logic             cin_i,
  output logic [WIDTH-1:0] sum_o,
`ifdef AJW_ADDSUB_FLAGS_EN
  output logic             ovf_o,
  output logic             zero_o,
`endif
  output logic             cout_o
);

  localparam int NGRP = WIDTH / GROUP;

  logic [NGRP-1:0]  grp_g;
  logic [NGRP-1:0]  grp_p;
  logic [NGRP:0]    grp_c;
  logic [WIDTH-1:0] sum_d;

  for (genvar gi = 0; gi < NGRP; gi++) begin : g_grp
    ajw_cla_group #(.GROUP(GROUP)) u_grp (
      .op_x (opX_i[gi*GROUP +: GROUP]),
      .op_y (opY_i[gi*GROUP +: GROUP]),
      .cin  (grp_c[gi]),
      .sum  (sum_d[gi*GROUP +: GROUP]),
      .gg   (grp_g[gi]),
      .gp   (grp_p[gi])
    );
  end

  // Carry into every group computed directly from cin_i, GG and GP: no inter-group ripple.
  always_comb begin
    logic acc;
    logic term;
    grp_c = '0;
    acc   = 1'b0;
    term  = 1'b0;
    for (int k = 0; k <= NGRP; k++) begin
      acc = cin_i;
      for (int j = 0; j < k; j++) acc = acc & grp_p[j];
      for (int j = 0; j < k; j++) begin
        term = grp_g[j];
        for (int m = j + 1; m < k; m++) term = term & grp_p[m];
        acc = acc | term;
      end
      grp_c[k] = acc;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sum_o  <= '0;
      cout_o <= 1'b0;
    end else begin
      sum_o  <= sum_d;
      cout_o <= grp_c[NGRP];
    end
  end

`ifdef AJW_ADDSUB_FLAGS_EN
  logic c_msb;
  logic ovf_d;

  // Carry into the MSB recovered from its sum and propagate bits.
  assign c_msb = sum_d[WIDTH-1] ^ opX_i[WIDTH-1] ^ opY_i[WIDTH-1];
  assign ovf_d = grp_c[NGRP] ^ c_msb;

  // zero_o clears in reset even though the reset sum is zero.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ovf_o  <= 1'b0;
      zero_o <= 1'b0;
    end else begin
      ovf_o  <= ovf_d;
      zero_o <= ~|sum_d;
    end
  end
`endif

endmodule

// File: tb/tb_ajw_addsub_core.sv
// Scoreboard bench for ajw_addsub_core; flag checks follow AJW_ADDSUB_FLAGS_EN.
module tb_ajw_addsub_core;
  import ajw_alu_pkg::*;

  logic  clk_i  = 1'b0;
  logic  rst_ni = 1'b0;
  word_t opX_i  = '0;
  word_t opY_i  = '0;
  logic  cin_i  = 1'b0;
  word_t sum_o;
  logic  cout_o;
`ifdef AJW_ADDSUB_FLAGS_EN
  logic  ovf_o;
  logic  zero_o;
`endif

  ajw_addsub_core dut (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .opX_i  (opX_i),
    .opY_i  (opY_i),
    .cin_i  (cin_i),
    .sum_o  (sum_o),
`ifdef AJW_ADDSUB_FLAGS_EN
    .ovf_o  (ovf_o),
    .zero_o (zero_o),
`endif
    .cout_o (cout_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    word_t sum;
    logic  cout;
    logic  ovf;
    logic  zero;
    string name;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   errors = 0;
  int   checks = 0;
  logic tb_vld = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic chk_outs(input string name, input word_t es, input logic ec,
                          input logic eo, input logic ez);
    chk({name, ".sum"}, sum_o, es);
    chk({name, ".cout"}, {31'b0, cout_o}, {31'b0, ec});
`ifdef AJW_ADDSUB_FLAGS_EN
    chk({name, ".ovf"}, {31'b0, ovf_o}, {31'b0, eo});
    chk({name, ".zero"}, {31'b0, zero_o}, {31'b0, ez});
`else
    if (eo === 1'bx || ez === 1'bx) $display("note: unknown flag expectation in %s", name);
`endif
  endtask

  task automatic issue(input word_t x, input word_t y, input logic c, input word_t es,
                       input logic ec, input logic eo, input logic ez, input string name);
    exp_t e;
    @(negedge clk_i);
    opX_i  = x;
    opY_i  = y;
    cin_i  = c;
    tb_vld = 1'b1;
    e.sum = es; e.cout = ec; e.ovf = eo; e.zero = ez; e.name = name;
    sb.push_back(e);
  endtask

  task automatic idle();
    @(negedge clk_i);
    tb_vld = 1'b0;
  endtask

  always @(posedge clk_i) begin
    if (tb_vld && rst_ni) begin
      #1;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL scoreboard: got output with no expectation, want queued entry");
      end else begin
        mon_e = sb.pop_front();
        chk_outs(mon_e.name, mon_e.sum, mon_e.cout, mon_e.ovf, mon_e.zero);
      end
    end
  end

  initial begin
    word_t    rx, ry;
    logic     rc;
    logic [32:0] full;
    logic     rovf;

    #1;
    chk_outs("reset0", 32'h0, 1'b0, 1'b0, 1'b0);
    @(negedge clk_i);
    rst_ni = 1'b1;

    // Back-to-back directed vectors, one per cycle
    issue(32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b1, "carry_all");
    issue(32'h00000005, 32'hFFFFFFFC, 1'b1, 32'h00000002, 1'b1, 1'b0, 1'b0, "sub_5_3");
    issue(32'h00000003, 32'hFFFFFFFA, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0, "sub_3_5");
    issue(32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 1'b0, 1'b1, 1'b0, "ovf_pos");
    issue(32'h80000000, 32'h80000000, 1'b0, 32'h00000000, 1'b1, 1'b1, 1'b1, "ovf_neg");
    issue(32'h00000000, 32'h00000000, 1'b1, 32'h00000001, 1'b0, 1'b0, 1'b0, "cin_only");
    issue(32'h00000000, 32'h00000000, 1'b0, 32'h00000000, 1'b0, 1'b0, 1'b1, "all_zero");
    issue(32'hAAAAAAAA, 32'h55555555, 1'b1, 32'h00000000, 1'b1, 1'b0, 1'b1, "alt_prop");
    issue(32'h0000FFFF, 32'h00000001, 1'b0, 32'h00010000, 1'b0, 1'b0, 1'b0, "grp_chain");
    issue(32'h80000000, 32'hFFFFFFFF, 1'b0, 32'h7FFFFFFF, 1'b1, 1'b1, 1'b0, "neg_wrap");
    issue(32'h00F0000F, 32'h000FFFF1, 1'b0, 32'h01000000, 1'b0, 1'b0, 1'b0, "mid_chain");
    idle();

    for (int i = 0; i < 200; i++) begin
      rx   = $urandom;
      ry   = $urandom;
      rc   = 1'($urandom_range(0, 1));
      full = {1'b0, rx} + {1'b0, ry} + {32'b0, rc};
      rovf = (rx[31] == ry[31]) && (full[31] != rx[31]);
      issue(rx, ry, rc, full[31:0], full[32], rovf, full[31:0] == 32'h0, "rand");
    end

    // Asynchronous reset between edges with a nonzero result on the outputs
    issue(32'h0F0F0F0F, 32'h01010101, 1'b0, 32'h10101010, 1'b0, 1'b0, 1'b0, "pre_rst");
    @(negedge clk_i);
    opX_i  = 32'h12345678;
    opY_i  = 32'h11111111;
    cin_i  = 1'b0;
    tb_vld = 1'b0;
    #2;
    rst_ni = 1'b0;
    #1;
    chk_outs("async_rst", 32'h0, 1'b0, 1'b0, 1'b0);
    @(negedge clk_i);
    chk_outs("rst_held", 32'h0, 1'b0, 1'b0, 1'b0);
    rst_ni = 1'b1;
    tb_vld = 1'b1;
    begin
      exp_t e;
      e.sum = 32'h23456789; e.cout = 1'b0; e.ovf = 1'b0; e.zero = 1'b0; e.name = "post_rst";
      sb.push_back(e);
    end
    idle();

    repeat (3) @(negedge clk_i);
    chk("sb_drained", sb.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/ajw_addsub_core.md
# ajw_addsub_core

32-bit adder/subtractor used as the arithmetic core of the in-order pipeline ALU. It computes `opX_i + opY_i + cin_i` through a two-level carry-lookahead network and registers the sum and carry-out. Subtraction is performed by the caller: it drives the one's complement of the subtrahend on `opY_i` and sets `cin_i`=1. The registered outputs feed the execute-stage result mux.

## Interface
Parameters:
- `WIDTH`, 32, operand and sum width; must be a multiple of `GROUP`.
- `GROUP`, 4, bits per carry-lookahead group.

Ports:
- `clk_i`  in  1  clock; all state updates on the rising edge.
- `rst_ni`  in  1  reset; asynchronous, active-low.
- `opX_i`  in  WIDTH  first operand.
- `opY_i`  in  WIDTH  second operand; for subtraction, the caller drives the inverted subtrahend here.
- `cin_i`  in  1  carry into bit 0.
- `sum_o`  out  WIDTH  registered `(opX_i + opY_i + cin_i) mod 2^WIDTH`.
- `cout_o`  out  1  registered carry out of bit WIDTH-1.
- `ovf_o`  out  1  registered signed overflow; present only with `AJW_ADDSUB_FLAGS_EN`.
- `zero_o`  out  1  registered flag, set when the sum is zero; present only with `AJW_ADDSUB_FLAGS_EN`.

## Operation
- Per bit i: `g[i] = opX[i] & opY[i]`, `p[i] = opX[i] ^ opY[i]`.
- Group level: each GROUP-bit block produces a group generate GG and group propagate GP.
- Top level: a lookahead unit computes the carry into every group from `cin_i`, GG and GP. There is no ripple between groups.
- In-group carries: `c[i+1] = g[i] | (p[i] & c[i])`, expanded as lookahead logic, not ripple.
- `sum[i] = p[i] ^ c[i]`.
- `cout = c[WIDTH]`.
- The result is unsigned modulo 2^WIDTH. For subtraction, `cout`=1 means no borrow (opX ≥ subtrahend, unsigned).
- `ovf = c[WIDTH] ^ c[WIDTH-1]`.
- `zero = ~|sum`.
- There is no handshake. A new operation is accepted every cycle.

## Timing
- Latency is 1 cycle: the inputs sampled at rising edge N appear on the outputs after edge N and stay stable until edge N+1.
- Throughput is 1 operation per cycle.
- Reset: when `rst_ni` goes low, `sum_o`=0, `cout_o`=0, `ovf_o`=0 and `zero_o`=0 immediately, independent of the clock.
  - `zero_o` resets to 0 even though the reset sum is 0.
- Reset release: the first valid result follows the first rising edge after `rst_ni` goes high.
- If reset is asserted mid-stream, the in-flight result is discarded. There is no recovery state.
- Combinational path: from an operand input to the register D-input. Depth is O(log WIDTH) through the two lookahead levels.
- X or undefined inputs are not filtered. They propagate to the register.

## Configuration
- `AJW_ADDSUB_FLAGS_EN` defined: the `ovf_o` and `zero_o` ports and their registers exist, computed as above.
- Not defined: both ports and their registers are removed. `sum_o` and `cout_o` are unaffected bit-for-bit.

## Structure
- Shared package `ajw_alu_pkg` holds:
  - `XLEN` = 32;
  - default `CLA_GROUP` = 4;
  - typedef `word_t` = `logic [XLEN-1:0]`.
- Sub-module `ajw_cla_group`:
  - inputs: GROUP-bit operands and carry-in;
  - outputs: GROUP sum bits, GG and GP.
- The top instantiates WIDTH/GROUP copies of `ajw_cla_group`, the group-level lookahead logic and the output registers.

## Test plan
- Carry propagation: `opX`=0xFFFFFFFF, `opY`=0x00000001, `cin`=0 → next cycle `sum`=0x00000000, `cout`=1; with flags, `zero`=1, `ovf`=0.
- Subtraction: `opX`=5, `opY`=~3 (0xFFFFFFFC), `cin`=1 → `sum`=2, `cout`=1.
  - Then `opX`=3, `opY`=~5, `cin`=1 → `sum`=0xFFFFFFFE, `cout`=0.
- Signed overflow: `opX`=0x7FFFFFFF, `opY`=1, `cin`=0 → `sum`=0x80000000, `cout`=0, `ovf`=1.
  - Also `opX`=`opY`=0x80000000 → `sum`=0, `cout`=1, `ovf`=1.
- Carry-in only: `opX`=`opY`=0, `cin`=1 → `sum`=1, `cout`=0.
  - Back-to-back distinct operations on consecutive cycles each appear exactly 1 cycle later.
- Asynchronous reset mid-operation: drive 0x12345678+0x11111111, then pull `rst_ni` low between edges → outputs go to 0 without a clock edge.
  - After release and one edge, `sum`=0x23456789.
- Random regression: 10k random `opX`/`opY`/`cin`, with the result checked against the behavioural 33-bit sum delayed by one cycle.
  - Repeat once with `AJW_ADDSUB_FLAGS_EN` defined and once without.
